// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined RISC-V immediate generator. Classifies each accepted 32-bit
//   instruction by format, builds its XLEN-wide immediate and queues the
//   result in a DEPTH-entry in-order FIFO between fetch and decode/execute.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; empties the FIFO
//   in_valid     producer offers in_instr/in_tag
//   in_ready     FIFO not full (registered state only)
//   in_instr     32-bit instruction word
//   in_tag       sideband tag, returned unchanged
//   out_valid    FIFO head is valid
//   out_ready    consumer takes the head entry
//   out_imm      immediate of the head entry (0 when empty)
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT (0 when empty)
//   out_illegal  opcode not recognised (0 when empty)
//   out_tag      tag of the head entry (0 when empty)
//   level        current occupancy
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [LVL_W-1:0] level
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [31:0]     imm32;
    logic [63:0]     imm64;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        opcode  = in_instr[6:0];
        funct3  = in_instr[14:12];
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: dec_fmt = FMT_I;
            7'b0010011, 7'b0011011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_fmt = FMT_I;
                end
            end
            7'b0100011:             dec_fmt = FMT_S;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            default:                dec_ill = 1'b1;
        endcase
    end

    // All sign-extended formats are first built as a 32-bit value, then
    // widened to 64 and truncated to XLEN so XLEN=32 needs no special case.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm64 = {{32{imm32[31]}}, imm32};

        if (dec_fmt == FMT_SHAMT) begin
            // 6-bit shift amount only for 64-bit OP-IMM; word shifts and
            // RV32 use 5 bits.
            if (opcode == 7'b0010011 && XLEN == 64) begin
                dec_imm = XLEN'(in_instr[25:20]);
            end else begin
                dec_imm = XLEN'(in_instr[24:20]);
            end
        end else begin
            dec_imm = imm64[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_q  [DEPTH];
    logic [2:0]       fmt_q  [DEPTH];
    logic             ill_q  [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            imm_q    <= '{default: '0};
            fmt_q    <= '{default: '0};
            ill_q    <= '{default: 1'b0};
            tag_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                ill_q[wr_ptr_q] <= dec_ill;
                tag_q[wr_ptr_q] <= in_tag;
            end
        end
    end

    // Head outputs are forced to zero whenever the FIFO is empty.
    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : '0;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
    assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;
    assign level       = level_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed cases, backpressure, asynchronous
// reset and randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance: XLEN=64, DEPTH=2
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [7:0]  in_tag, out_tag;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [1:0]  level;

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag), .level(level)
    );

    // Second instance: XLEN=32, DEPTH=1
    logic        b_valid, b_in_ready, b_out_valid, b_ready, b_illegal;
    logic [31:0] b_instr;
    logic [7:0]  b_tag, b_out_tag;
    logic [31:0] b_imm;
    logic [2:0]  b_fmt;
    logic [0:0]  b_level;

    imm_gen_pipe #(.XLEN(32), .DEPTH(1), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(b_valid), .in_ready(b_in_ready), .in_instr(b_instr), .in_tag(b_tag),
        .out_valid(b_out_valid), .out_ready(b_ready), .out_imm(b_imm), .out_fmt(b_fmt),
        .out_illegal(b_illegal), .out_tag(b_out_tag), .level(b_level)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } ent_t;

    ent_t q[$];

    function automatic longint fld(input logic [31:0] ins, input int hi, input int lo);
        longint w;
        w = longint'(ins);
        return (w >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Interpret a w-bit unsigned field as two's complement.
    function automatic longint sx(input longint v, input int w);
        return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
    endfunction

    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [7:0] tag, input int xlen);
        ent_t   e;
        longint v;
        int     op, f3;
        op = int'(fld(ins, 6, 0));
        f3 = int'(fld(ins, 14, 12));
        v = 0;
        e.ill = 1'b0;
        e.fmt = 3'd0;
        if (op == 'h03 || op == 'h67) begin
            e.fmt = 3'd1; v = sx(fld(ins, 31, 20), 12);
        end else if (op == 'h13 || op == 'h1B) begin
            if (f3 == 1 || f3 == 5) begin
                e.fmt = 3'd6;
                v = (op == 'h13 && xlen == 64) ? fld(ins, 25, 20) : fld(ins, 24, 20);
            end else begin
                e.fmt = 3'd1; v = sx(fld(ins, 31, 20), 12);
            end
        end else if (op == 'h23) begin
            e.fmt = 3'd2; v = sx(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12);
        end else if (op == 'h63) begin
            e.fmt = 3'd3;
            v = sx(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048
                 + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2, 13);
        end else if (op == 'h37 || op == 'h17) begin
            e.fmt = 3'd4; v = sx(fld(ins, 31, 12) * 4096, 32);
        end else if (op == 'h6F) begin
            e.fmt = 3'd5;
            v = sx(fld(ins, 31, 31) * (longint'(1) << 20) + fld(ins, 19, 12) * 4096
                 + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2, 21);
        end else begin
            e.ill = 1'b1;
        end
        e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
        e.tag = tag;
        return e;
    endfunction

    task automatic check_outputs();
        int n;
        n = q.size();
        check("out_valid", 64'(out_valid), 64'(n > 0));
        check("level", 64'(level), 64'(n));
        check("in_ready", 64'(in_ready), 64'(n < 2));
        if (n > 0) begin
            check("out_imm", out_imm, q[0].imm);
            check("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
            check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
        end else begin
            check("out_imm_empty", out_imm, 64'd0);
            check("out_fmt_empty", 64'(out_fmt), 64'd0);
            check("out_ill_empty", 64'(out_illegal), 64'd0);
            check("out_tag_empty", 64'(out_tag), 64'd0);
        end
    endtask

    // Called shortly after a rising edge: drive one cycle, advance the model
    // at the next edge, then compare.
    task automatic step(input logic v, input logic [31:0] ins, input logic [7:0] tg, input logic rdy);
        logic do_push, do_pop;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = rdy;
        do_push = v && (q.size() < 2);
        do_pop  = rdy && (q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ref_decode(ins, tg, 64));
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        in_valid = 0; in_instr = '0; in_tag = '0; out_ready = 0;
        b_valid = 0; b_instr = '0; b_tag = '0; b_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_outputs();

        // Single addi x1,x0,-4
        step(1, 32'hFFC00093, 8'h01, 1);
        check("addi_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        check("addi_fmt", 64'(out_fmt), 64'd1);
        check("addi_tag", 64'(out_tag), 64'h01);

        // Back-to-back with out_ready high: one result per cycle
        step(1, 32'h00303423, 8'h02, 1);
        check("sd_imm", out_imm, 64'h8);
        check("sd_fmt", 64'(out_fmt), 64'd2);
        step(1, 32'h00208863, 8'h03, 1);
        check("beq_imm", out_imm, 64'h10);
        check("beq_fmt", 64'(out_fmt), 64'd3);
        step(1, 32'hFFFFF06F, 8'h04, 1);
        check("jal_imm", out_imm, 64'hFFFFFFFFFFFFFFFE);
        check("jal_fmt", 64'(out_fmt), 64'd5);
        step(1, 32'h02129213, 8'h05, 1);
        check("slli_imm", out_imm, 64'h21);
        check("slli_fmt", 64'(out_fmt), 64'd6);
        step(1, 32'h800000B7, 8'h06, 1);
        check("lui_imm", out_imm, 64'hFFFFFFFF80000000);
        check("lui_fmt", 64'(out_fmt), 64'd4);
        step(1, 32'h0000007F, 8'h07, 1);
        check("ill_flag", 64'(out_illegal), 64'd1);
        check("ill_imm", out_imm, 64'd0);
        step(0, '0, '0, 1);

        // Backpressure: tag 3 held while full
        step(1, 32'hFFC00093, 8'h01, 0);
        step(1, 32'h00303423, 8'h02, 0);
        step(1, 32'h00208863, 8'h03, 0);
        check("bp_level", 64'(level), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_tag", 64'(out_tag), 64'h01);
        step(1, 32'h00208863, 8'h03, 0);
        check("bp_stable_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        step(1, 32'h00208863, 8'h03, 1);
        check("bp_tag2", 64'(out_tag), 64'h02);
        step(1, 32'h00208863, 8'h03, 1);
        check("bp_tag3", 64'(out_tag), 64'h03);
        step(0, '0, '0, 1);

        // Asynchronous reset while full
        step(1, 32'h00303423, 8'h0A, 0);
        step(1, 32'hFFFFF06F, 8'h0B, 0);
        check("pre_rst_level", 64'(level), 64'd2);
        in_valid = 0;
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        check_outputs();
        step(1, 32'hFFC00093, 8'h0C, 1);
        check("post_rst_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        step(0, '0, '0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        step(0, '0, '0, 1);
        step(0, '0, '0, 1);

        // XLEN=32, DEPTH=1 instance
        b_valid = 1; b_instr = 32'h800000B7; b_tag = 8'h21; b_ready = 0;
        @(posedge clk); #1;
        check("r32_valid", 64'(b_out_valid), 64'd1);
        check("r32_in_ready", 64'(b_in_ready), 64'd0);
        check("r32_lui_imm", 64'(b_imm), 64'h80000000);
        check("r32_lui_fmt", 64'(b_fmt), 64'd4);
        check("r32_tag", 64'(b_out_tag), 64'h21);
        b_instr = 32'h02129213; b_tag = 8'h22; b_ready = 1;
        @(posedge clk); #1;
        check("r32_drained", 64'(b_out_valid), 64'd0);
        check("r32_empty_imm", 64'(b_imm), 64'd0);
        @(posedge clk); #1;
        check("r32_shamt_imm", 64'(b_imm), 64'h1);
        check("r32_shamt_fmt", 64'(b_fmt), 64'd6);
        b_instr = 32'hFFC00093; b_tag = 8'h23;
        repeat (2) @(posedge clk);
        #1;
        check("r32_addi_imm", 64'(b_imm), 64'hFFFFFFFC);
        check("r32_addi_tag", 64'(b_out_tag), 64'h23);
        check("r32_level", 64'(b_level), 64'd1);
        b_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the combinational `ImmGen`. It accepts 32-bit RISC-V instructions over a valid/ready handshake and classifies each by format. It produces the sign- or zero-extended immediate at `XLEN` width and buffers results in a `DEPTH`-entry in-order FIFO. It sits between fetch and the decode/execute stage and decouples them with backpressure.

## Interface
- `XLEN`, default 64: immediate width; legal values are 32 and 64.
- `DEPTH`, default 2: result FIFO entries; a power of two, ≥1.
- `TAG_W`, default 8: width of the sideband tag passed through with each instruction.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  producer has an instruction.
- `in_ready`  out  1  block can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband, returned unchanged.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_imm`  out  XLEN  immediate.
- `out_fmt`  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- `out_illegal`  out  1  opcode not recognised.
- `out_tag`  out  TAG_W  tag of the head entry.
- `level`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Decode is combinational on `in_instr` and is captured into the FIFO on accept (`in_valid && in_ready`).
- Opcode map, `in_instr[6:0]`:
  - 0000011, 1100111: I.
  - 0010011, 0011011: I, except funct3 001/101, which are SHAMT.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - Any other opcode: NONE with `out_illegal`=1 and imm=0.
- Immediate assembly per format:
  - I: `instr[31:20]`, sign-extended.
  - S: `{instr[31:25],instr[11:7]}`, sign-extended.
  - B: `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}`, sign-extended.
  - U: `{instr[31:12],12'b0}`, sign-extended to XLEN (no-op at XLEN=32).
  - J: `{instr[31],instr[19:12],instr[20],instr[30:21],1'b0}`, sign-extended.
- SHAMT is zero-extended:
  - Opcode 0010011 with XLEN=64: `instr[25:20]`.
  - Opcode 0011011, or XLEN=32: `instr[24:20]`.
- FIFO rules:
  - Strictly in order.
  - Pop on `out_valid && out_ready`.
  - Read/write pointers wrap modulo DEPTH.
- `in_ready` = (`level` != DEPTH). It depends only on registered state; there is no combinational path from `out_ready`.
- Simultaneous push and pop: `level` unchanged, both pointers advance. A push at full is impossible because `in_ready` is low.
- When empty, `out_imm`, `out_fmt`, `out_illegal` and `out_tag` are driven to 0.
- While `out_valid && !out_ready`, all `out_*` stay stable.

## Timing
- Latency is 1 cycle with no bypass. An instruction accepted at edge N is presented with `out_valid`=1 after edge N, and can be popped at edge N+1 at the earliest.
- Throughput is 1 per cycle when `out_ready` is held high (any DEPTH ≥1 sustains it only when DEPTH ≥2; with DEPTH=1 it is 1 per 2 cycles).
- Reset values:
  - `out_valid`=0, `level`=0, `in_ready`=1.
  - All `out_*` data = 0.
  - Pointers = 0.
- Reset asserted mid-operation discards every buffered entry immediately (asynchronously). After deassertion, the first accept behaves as from empty.

## Test plan
- XLEN=64, push `0xFFC00093` (addi x1,x0,-4), tag 0x01, `out_ready`=1 -> next cycle: `out_valid`=1, `out_imm`=FFFFFFFFFFFFFFFC, `out_fmt`=1, `out_tag`=0x01, `level`=1.
- Back-to-back:
  - Push `0x00303423` (sd) -> imm 0x8, fmt 2.
  - Push `0x00208863` (beq) -> imm 0x10, fmt 3.
  - Push `0xFFFFF06F` (jal -2) -> imm FFFFFFFFFFFFFFFE, fmt 5.
  - `out_ready` held high -> one result per cycle, in order.
- Shift and upper immediates:
  - Push `0x02129213` (slli x4,x5,33) -> imm 0x21, fmt 6.
  - Push `0x800000B7` (lui) -> imm FFFFFFFF80000000 at XLEN=64, and 80000000 at XLEN=32.
- Illegal opcode: push `0x0000007F` -> `out_illegal`=1, `out_fmt`=0, `out_imm`=0.
- Backpressure, DEPTH=2, `out_ready`=0:
  - Offer tags 1,2,3 -> tags 1,2 are accepted, `level`=2, `in_ready`=0, tag 3 is held.
  - Raise `out_ready` -> tags 1,2,3 emerge in order, with `out_*` stable during the stall.
- With `level`=2, assert `reset` for 1 cycle -> `out_valid`=0, `level`=0, `in_ready`=1 immediately. Next push emerges after 1 cycle with the correct imm.
